// File: rtl/cpp_d2i_pkg.sv
// Shared constants and stage payload types for the binary64 -> signed integer pipeline.
package cpp_d2i_pkg;

  localparam logic [1:0] MODE_TRUNC = 2'b00;
  localparam logic [1:0] MODE_RNE   = 2'b01;
  localparam logic [1:0] MODE_FLOOR = 2'b10;
  localparam logic [1:0] MODE_CEIL  = 2'b11;

  localparam int unsigned FLAG_INEXACT  = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_INVALID  = 2;
  localparam int unsigned FLAG_W        = 3;

  localparam int unsigned DBL_W    = 64;
  localparam int unsigned EXP_W    = 11;
  localparam int unsigned FRAC_W   = 52;
  localparam int unsigned SIG_W    = FRAC_W + 1;
  localparam int unsigned EXP_BIAS = 1023;
  localparam int unsigned MODE_W   = 2;

  // Integer magnitude kept by the align stage; anything wider is tracked by a flag.
  localparam int unsigned MAG_W   = 64;
  localparam int unsigned LSB_EXP = EXP_BIAS + FRAC_W;
  localparam int unsigned BIG_EXP = EXP_BIAS + MAG_W;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [SIG_W-1:0]  sig;
    logic              nan;
    logic              inf;
    logic [MODE_W-1:0] mode;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic [MAG_W-1:0]  mag;
    logic              big;
    logic              guard;
    logic              sticky;
    logic              nan;
    logic              inf;
    logic [MODE_W-1:0] mode;
  } s2_t;

endpackage

// File: rtl/cpp_d2i_round.sv
// Rounding-increment and inexact decision for one aligned magnitude.
module cpp_d2i_round
  import cpp_d2i_pkg::*;
(
  input  logic [MODE_W-1:0] mode,
  input  logic              sign,
  input  logic              lsb,
  input  logic              guard,
  input  logic              sticky,
  output logic              inc_c,
  output logic              inexact_c
);

  always_comb begin
    inc_c     = 1'b0;
    inexact_c = guard | sticky;
    case (mode)
      MODE_TRUNC: inc_c = 1'b0;
      MODE_RNE:   inc_c = guard & (sticky | lsb);
      MODE_FLOOR: inc_c = sign & (guard | sticky);
      MODE_CEIL:  inc_c = ~sign & (guard | sticky);
      default:    inc_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpp_double_to_int_pipe.sv
// Three-stage binary64 to signed OUT_W-bit integer converter with a globally stalled valid/ready pipe.
module cpp_double_to_int_pipe
  import cpp_d2i_pkg::*;
#(
  parameter int unsigned OUT_W  = 32,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DBL_W-1:0]  in,
  input  logic [MODE_W-1:0] mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out,
  output logic [FLAG_W-1:0] flags,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned RND_W  = MAG_W + 1;
  localparam int unsigned WIDE_W = 2 * MAG_W;
  localparam logic [RND_W-1:0] NEG_LIM = RND_W'(1) << (OUT_W - 1);
  localparam logic [RND_W-1:0] POS_LIM = NEG_LIM - RND_W'(1);
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic advance;
  logic s1_v, s2_v;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S1: unpack fields and classify specials.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = in[DBL_W-1];
    s1_d.exp  = in[FRAC_W +: EXP_W];
    s1_d.sig  = {|in[FRAC_W +: EXP_W], in[FRAC_W-1:0]};
    s1_d.nan  = (&in[FRAC_W +: EXP_W]) && (|in[FRAC_W-1:0]);
    s1_d.inf  = (&in[FRAC_W +: EXP_W]) && !(|in[FRAC_W-1:0]);
    s1_d.mode = mode;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (advance) begin
      s1_v <= in_valid;
      s1_q <= s1_d;
    end
  end

  // S2: align the significand to the integer point, keeping guard and sticky.
  logic [EXP_W-1:0]  sh_l, sh_r;
  logic [WIDE_W-1:0] wide_r;

  always_comb begin
    s2_d      = '0;
    sh_l      = s1_q.exp - EXP_W'(LSB_EXP);
    sh_r      = EXP_W'(LSB_EXP) - s1_q.exp;
    wide_r    = {{(MAG_W-SIG_W){1'b0}}, s1_q.sig, {MAG_W{1'b0}}} >> sh_r;
    s2_d.sign = s1_q.sign;
    s2_d.nan  = s1_q.nan;
    s2_d.inf  = s1_q.inf;
    s2_d.mode = s1_q.mode;
    if (s1_q.exp >= EXP_W'(LSB_EXP)) begin
      // Exact integer; the low MAG_W bits are all a wrapped result ever needs.
      s2_d.mag = MAG_W'(s1_q.sig) << sh_l;
      s2_d.big = s1_q.exp >= EXP_W'(BIG_EXP);
    end else if (sh_r >= EXP_W'(MAG_W)) begin
      s2_d.sticky = |s1_q.sig;
    end else begin
      s2_d.mag    = wide_r[WIDE_W-1:MAG_W];
      s2_d.guard  = wide_r[MAG_W-1];
      s2_d.sticky = |wide_r[MAG_W-2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_q <= '0;
    end else if (advance) begin
      s2_v <= s1_v;
      s2_q <= s2_d;
    end
  end

  // S3: round, range-check, then saturate or wrap.
  logic              inc, inexact_raw, ovf;
  logic [RND_W-1:0]  rounded;
  logic [OUT_W-1:0]  low, wrap, sat, out_d;
  logic [FLAG_W-1:0] flags_d;

  cpp_d2i_round u_round (
    .mode      (s2_q.mode),
    .sign      (s2_q.sign),
    .lsb       (s2_q.mag[0]),
    .guard     (s2_q.guard),
    .sticky    (s2_q.sticky),
    .inc_c     (inc),
    .inexact_c (inexact_raw)
  );

  always_comb begin
    out_d   = '0;
    flags_d = '0;
    rounded = RND_W'(s2_q.mag) + RND_W'(inc);
    low     = OUT_W'(rounded);
    wrap    = s2_q.sign ? (~low + OUT_W'(1)) : low;
    sat     = s2_q.sign ? SAT_MIN : SAT_MAX;
    ovf     = s2_q.big || (rounded > (s2_q.sign ? NEG_LIM : POS_LIM));
    if (s2_q.nan) begin
      flags_d[FLAG_INVALID] = 1'b1;
    end else if (s2_q.inf) begin
      flags_d[FLAG_OVERFLOW] = 1'b1;
      out_d = SAT_EN ? sat : '0;
    end else if (ovf) begin
      flags_d[FLAG_OVERFLOW] = 1'b1;
      out_d = SAT_EN ? sat : wrap;
    end else begin
      flags_d[FLAG_INEXACT] = inexact_raw;
      out_d = wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= s2_v;
      if (s2_v) begin
        out   <= out_d;
        flags <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_cpp_double_to_int_pipe.sv
// Directed bench: a saturating 32-bit instance and a wrapping 64-bit instance share one stimulus stream.
module tb_cpp_double_to_int_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] din;
  logic [1:0]  mode;
  logic        in_valid, out_ready;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [31:0] out_a;
  logic [63:0] out_b;
  logic [2:0]  flags_a, flags_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] in;
    logic [1:0]  mode;
    logic [31:0] ea;
    logic [2:0]  fa;
    logic [63:0] eb;
    logic [2:0]  fb;
  } vec_t;

  typedef struct {
    logic [63:0] o;
    logic [2:0]  f;
  } res_t;

  vec_t vecs[$];
  res_t qa[$], qb[$];

  always #5 clk = ~clk;

  cpp_double_to_int_pipe #(.OUT_W(32), .SAT_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(din), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready_a), .out(out_a), .flags(flags_a), .out_valid(out_valid_a),
    .out_ready(out_ready)
  );

  cpp_double_to_int_pipe #(.OUT_W(64), .SAT_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(din), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready_b), .out(out_b), .flags(flags_b), .out_valid(out_valid_b),
    .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic add(input logic [63:0] in, input logic [1:0] m, input logic [31:0] ea,
                     input logic [2:0] fa, input logic [63:0] eb, input logic [2:0] fb);
    vec_t v;
    v.in = in; v.mode = m; v.ea = ea; v.fa = fa; v.eb = eb; v.fb = fb;
    vecs.push_back(v);
  endtask

  task automatic push_expect(input int idx);
    res_t r;
    r.o = {32'h0, vecs[idx].ea}; r.f = vecs[idx].fa;
    qa.push_back(r);
    r.o = vecs[idx].eb; r.f = vecs[idx].fb;
    qb.push_back(r);
  endtask

  // Output scoreboard: every valid output is compared, stalled or not.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_a) begin
        if (qa.size() == 0) check("spurious_valid_a", out_valid_a, 0);
        else begin
          check("out_a", out_a, qa[0].o);
          check("flags_a", flags_a, qa[0].f);
          if (out_ready) void'(qa.pop_front());
        end
      end
      if (out_valid_b) begin
        if (qb.size() == 0) check("spurious_valid_b", out_valid_b, 0);
        else begin
          check("out_b", out_b, qb[0].o);
          check("flags_b", flags_b, qb[0].f);
          if (out_ready) void'(qb.pop_front());
        end
      end
    end
  end

  // Presents vecs[first..first+n-1] back-to-back; out_ready is low in cycles stall_lo..stall_hi.
  task automatic run_stream(input int first, input int n, input int stall_lo, input int stall_hi);
    int  sent = 0;
    int  cyc  = 0;
    logic rdy;
    while ((sent < n || qa.size() != 0 || qb.size() != 0) && cyc < 300) begin
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      in_valid  = (sent < n);
      if (sent < n) begin
        din  = vecs[first+sent].in;
        mode = vecs[first+sent].mode;
      end
      @(negedge clk);
      rdy = in_ready_a;
      if (stall_lo >= 0 && cyc <= stall_hi) begin
        check($sformatf("in_ready_a_c%0d", cyc), in_ready_a, (cyc >= stall_lo) ? 0 : 1);
        check($sformatf("in_ready_b_c%0d", cyc), in_ready_b, (cyc >= stall_lo) ? 0 : 1);
      end
      @(posedge clk);
      if (in_valid && rdy) begin
        push_expect(first + sent);
        sent++;
      end
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_drain_a", qa.size(), 0);
    check("stream_drain_b", qb.size(), 0);
  endtask

  // One beat into an empty pipe; latency counts rising edges from acceptance to out_valid.
  task automatic latency_test(input int idx, input string name);
    int n;
    out_ready = 1'b1;
    din       = vecs[idx].in;
    mode      = vecs[idx].mode;
    in_valid  = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready_a, 1);
    @(posedge clk);
    push_expect(idx);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid_a && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, n, 3);
    check({name, "_valid_b"}, out_valid_b, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_out_a"}, out_a, 0);
    check({name, "_flags_a"}, flags_a, 0);
    check({name, "_valid_a"}, out_valid_a, 0);
    check({name, "_ready_a"}, in_ready_a, 1);
    check({name, "_out_b"}, out_b, 0);
    check({name, "_valid_b"}, out_valid_b, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //   in                     mode   A(32,sat)     fA     B(64,wrap)             fB
    add(64'h400D99999999999A, 2'b00, 32'h00000003, 3'b001, 64'h0000000000000003, 3'b001);
    add(64'h400D99999999999A, 2'b01, 32'h00000004, 3'b001, 64'h0000000000000004, 3'b001);
    add(64'hC004000000000000, 2'b01, 32'hFFFFFFFE, 3'b001, 64'hFFFFFFFFFFFFFFFE, 3'b001);
    add(64'hC004000000000000, 2'b10, 32'hFFFFFFFD, 3'b001, 64'hFFFFFFFFFFFFFFFD, 3'b001);
    add(64'hC004000000000000, 2'b11, 32'hFFFFFFFE, 3'b001, 64'hFFFFFFFFFFFFFFFE, 3'b001);
    add(64'hC004000000000000, 2'b00, 32'hFFFFFFFE, 3'b001, 64'hFFFFFFFFFFFFFFFE, 3'b001);
    add(64'h41E0000000000000, 2'b00, 32'h7FFFFFFF, 3'b010, 64'h0000000080000000, 3'b000);
    add(64'hC1E0000000000000, 2'b00, 32'h80000000, 3'b000, 64'hFFFFFFFF80000000, 3'b000);
    add(64'h7FF8000000000000, 2'b01, 32'h00000000, 3'b100, 64'h0000000000000000, 3'b100);
    add(64'h43F0000000000000, 2'b00, 32'h7FFFFFFF, 3'b010, 64'h0000000000000000, 3'b010);
    add(64'hBFD999999999999A, 2'b11, 32'h00000000, 3'b001, 64'h0000000000000000, 3'b001);
    add(64'h8000000000000000, 2'b01, 32'h00000000, 3'b000, 64'h0000000000000000, 3'b000);
    add(64'h7FF0000000000000, 2'b00, 32'h7FFFFFFF, 3'b010, 64'h0000000000000000, 3'b010);
    add(64'hFFF0000000000000, 2'b00, 32'h80000000, 3'b010, 64'h0000000000000000, 3'b010);
    add(64'h3FE0000000000000, 2'b01, 32'h00000000, 3'b001, 64'h0000000000000000, 3'b001);
    add(64'h3FE0000000000000, 2'b11, 32'h00000001, 3'b001, 64'h0000000000000001, 3'b001);
    add(64'h3FF8000000000000, 2'b01, 32'h00000002, 3'b001, 64'h0000000000000002, 3'b001);
    add(64'h0000000000000001, 2'b11, 32'h00000001, 3'b001, 64'h0000000000000001, 3'b001);
    add(64'h0000000000000001, 2'b10, 32'h00000000, 3'b001, 64'h0000000000000000, 3'b001);
    add(64'hC1E0000000200000, 2'b00, 32'h80000000, 3'b010, 64'hFFFFFFFF7FFFFFFF, 3'b000);
    add(64'hC1E0000000100000, 2'b00, 32'h80000000, 3'b001, 64'hFFFFFFFF80000000, 3'b001);
    add(64'hC1E0000000100000, 2'b10, 32'h80000000, 3'b010, 64'hFFFFFFFF7FFFFFFF, 3'b001);
    add(64'h43E0000000000000, 2'b00, 32'h7FFFFFFF, 3'b010, 64'h8000000000000000, 3'b010);
    add(64'hC3E0000000000000, 2'b00, 32'h80000000, 3'b010, 64'h8000000000000000, 3'b000);

    rst_n = 1'b0; in_valid = 1'b0; din = '0; mode = 2'b00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    latency_test(0, "first_trunc");
    latency_test(1, "first_rne");

    run_stream(0, vecs.size(), -1, -1);
    run_stream(0, 8, 4, 7);

    // Two beats in flight, then a one-cycle reset pulse.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    din = vecs[2].in; mode = vecs[2].mode;
    @(posedge clk); #1;
    din = vecs[3].in; mode = vecs[3].mode;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_valid_a_%0d", i), out_valid_a, 0);
      check($sformatf("post_reset_valid_b_%0d", i), out_valid_b, 0);
    end
    @(posedge clk); #1;
    latency_test(15, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpp_double_to_int_pipe.md
CPP_DOUBLE_TO_INT_PIPE -- requirements
Module: cpp_double_to_int_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter OUT_W, default 32, SHALL set the signed integer result width; legal range 8..64.
REQ-003 Parameter SAT_EN, default 1, SHALL select out-of-range handling: 1 = saturate, 0 = return the C-style wrapped low OUT_W bits.
REQ-004 Port clk, input, 1: the single clock; every flop is rising-edge triggered.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port in, input, 64: IEEE-754 binary64 operand.
REQ-007 Port mode, input, 2: rounding mode sampled with in. 00 = trunc toward zero, 01 = nearest-even, 10 = floor, 11 = ceil.
REQ-008 Port in_valid, input, 1: the in/mode beat is valid.
REQ-009 Port in_ready, output, 1: the block accepts a beat this cycle.
REQ-010 Port out, output, OUT_W: signed two's-complement result.
REQ-011 Port flags, output, 3: {invalid, overflow, inexact}.
REQ-012 Port out_valid, output, 1: out and flags are valid.
REQ-013 Port out_ready, input, 1: the downstream sink accepts out.

Function
REQ-014 A beat SHALL transfer on a rising edge where in_valid && in_ready; output handoff SHALL occur on a rising edge where out_valid && out_ready.
REQ-015 The block SHALL be a 3-stage pipeline: S1 unpack/classify, S2 align shift, S3 round/saturate/register. Latency is exactly 3 cycles without stall; throughput is 1 beat/cycle.
REQ-016 Pipeline advance SHALL be global: advance = !out_valid || out_ready. in_ready SHALL equal advance, combinationally, with no dependence on in_valid.
REQ-017 A stall SHALL hold every stage register, and out/flags SHALL stay stable while out_valid && !out_ready.
REQ-018 Bubbles SHALL propagate: a stage with no valid beat does not block advance of earlier stages.
REQ-019 Magnitude SHALL be computed exactly from the 53-bit significand with guard and sticky bits; shifts of 64 or more SHALL yield zero with sticky = OR of all significand bits.
REQ-020 Rounding increment per mode:
  - trunc: none.
  - nearest-even: guard && (sticky || lsb).
  - floor: negative && (guard || sticky).
  - ceil: positive && (guard || sticky).
REQ-021 inexact SHALL be 1 when guard || sticky and the result is neither invalid nor overflowed.
REQ-022 Zero and subnormal inputs SHALL be treated as magnitude < 1 and rounded per mode. -0.0 SHALL give 0 with inexact = 0.
REQ-023 NaN SHALL give out = 0 and invalid = 1.
REQ-024 When the rounded value, +Inf or -Inf exceeds the OUT_W signed range and SAT_EN = 1, the result SHALL be 2^(OUT_W-1)-1 or -2^(OUT_W-1) as appropriate, with overflow = 1.
REQ-025 When SAT_EN = 0, an out-of-range finite result SHALL be the low OUT_W bits of the exact rounded integer, with overflow = 1. ±Inf SHALL give 0 with overflow = 1.
REQ-026 An exact -2^(OUT_W-1) SHALL NOT set overflow.
REQ-027 mode SHALL be captured in S1 and travel with its beat; a change of mode between beats SHALL NOT affect beats already in flight.

Reset
REQ-028 While rst_n = 0, out = 0, flags = 0, out_valid = 0, and all stage-valid bits SHALL be 0; in_ready is therefore 1.
REQ-029 Assertion of reset mid-operation SHALL discard all in-flight beats, with no output after release.
REQ-030 The first beat SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package cpp_d2i_pkg SHALL hold the mode encoding constants, the flag bit indices, and the binary64 field widths and exponent bias (1023).
REQ-032 Sub-module cpp_d2i_round SHALL compute the rounding increment and inexact from {mode, sign, lsb, guard, sticky}; it SHALL be purely combinational and instantiated in S3.

Verification
REQ-033 0x400D99999999999A (3.7): trunc -> 3, flags 001; nearest-even -> 4, flags 001; out_valid exactly 3 cycles after acceptance.
REQ-034 0xC004000000000000 (-2.5): nearest-even -> -2; floor -> -3; ceil -> -2; trunc -> -2; all with inexact = 1.
REQ-035 OUT_W = 32: 0x41E0000000000000 (2^31) -> 0x7FFFFFFF, flags 010; 0xC1E0000000000000 (-2^31) -> 0x80000000, flags 000; 0x7FF8000000000000 (NaN) -> 0, flags 100.
REQ-036 Stream 8 back-to-back beats with out_ready held low for cycles 4..7 -> in_ready low on those cycles, no beat lost or duplicated, order preserved, out stable while stalled.
REQ-037 Pulse rst_n low for 1 cycle with 2 beats in flight -> out_valid stays 0 after release, and the next beat emerges with latency 3.
REQ-038 OUT_W = 64, SAT_EN = 0: 0x43F0000000000000 (2^64) -> 0, flags 010; 0xBFD999999999999A (-0.4) in ceil -> 0, flags 001.
